// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice path: envelope state encoding,
// level width/limits and the step-normalisation helper.
package synth_pkg;

    localparam int ENV_LEVEL_W = 8;
    localparam logic [ENV_LEVEL_W-1:0] ENV_LEVEL_MAX = 8'd255;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    // A zero step means "instant": use the full-scale step so one tick saturates.
    function automatic logic [ENV_LEVEL_W:0] eff_step(input logic [ENV_LEVEL_W-1:0] step);
        if (step == 8'd0) begin
            return {1'b0, ENV_LEVEL_MAX};
        end else begin
            return {1'b0, step};
        end
    endfunction

endpackage

// File: rtl/env_tick_gen.sv
// Free-running envelope prescaler: one-cycle tick every TICK_DIV clocks.
module env_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] TERM_C = 16'(TICK_DIV - 1);

    logic [15:0] cnt_r;

    // Prescale counter, wraps after the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (cnt_r == TERM_C) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign tick = (cnt_r == TERM_C);

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope and sample scaler. Define ENV_RETRIG_EN for hard retrigger
// (rise in any active state restarts ATTACK from level 0); default is legato.
module env_adsr
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [7:0]  atk_step,
    input  logic [7:0]  dec_step,
    input  logic [7:0]  sus_lvl,
    input  logic [7:0]  rel_step,
    input  logic [15:0] sig_in,
    output logic [15:0] sig_out,
    output logic [7:0]  level,
    output logic        active
);

    logic                   tick_s;
    logic                   gate_d_r;
    logic                   rise_s;
    logic                   fall_s;
    logic                   retrig_s;
    env_state_e             state_r;
    env_state_e             state_nxt_s;
    env_state_e             tick_state_s;
    logic [ENV_LEVEL_W-1:0] level_r;
    logic [ENV_LEVEL_W-1:0] level_nxt_s;
    logic [ENV_LEVEL_W-1:0] tick_level_s;
    logic [ENV_LEVEL_W:0]   lvl9_s;
    logic [ENV_LEVEL_W:0]   atk_sum_s;
    logic [ENV_LEVEL_W:0]   dec_floor_s;
    logic [ENV_LEVEL_W:0]   dec_diff_s;
    logic [ENV_LEVEL_W:0]   rel_diff_s;
    logic signed [24:0]     prod_s;
    logic                   active_r;
    logic [15:0]            sig_out_r;

    env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign rise_s = gate & ~gate_d_r;
    assign fall_s = ~gate & gate_d_r;

`ifdef ENV_RETRIG_EN
    assign retrig_s = rise_s;
`else
    assign retrig_s = 1'b0;
`endif

    // 9-bit intermediates keep every add/subtract free of wrap-around.
    assign lvl9_s      = {1'b0, level_r};
    assign atk_sum_s   = lvl9_s + eff_step(atk_step);
    assign dec_floor_s = {1'b0, sus_lvl} + eff_step(dec_step);
    assign dec_diff_s  = lvl9_s - eff_step(dec_step);
    assign rel_diff_s  = lvl9_s - eff_step(rel_step);

    // Level and state a tick would produce in the current state.
    always_comb begin
        tick_state_s = state_r;
        tick_level_s = level_r;
        case (state_r)
            ENV_ATTACK: begin
                if (atk_sum_s >= {1'b0, ENV_LEVEL_MAX}) begin
                    tick_level_s = ENV_LEVEL_MAX;
                    tick_state_s = ENV_DECAY;
                end else begin
                    tick_level_s = atk_sum_s[7:0];
                end
            end
            ENV_DECAY: begin
                if (lvl9_s <= dec_floor_s) begin
                    tick_level_s = sus_lvl;
                    tick_state_s = ENV_SUSTAIN;
                end else begin
                    tick_level_s = dec_diff_s[7:0];
                end
            end
            ENV_SUSTAIN: begin
                tick_level_s = sus_lvl;
            end
            ENV_RELEASE: begin
                if (lvl9_s <= eff_step(rel_step)) begin
                    tick_level_s = 8'd0;
                    tick_state_s = ENV_IDLE;
                end else begin
                    tick_level_s = rel_diff_s[7:0];
                end
            end
            default: begin
                tick_state_s = ENV_IDLE;
                tick_level_s = 8'd0;
            end
        endcase
    end

    // Gate events take priority over tick updates: rise, then fall, then tick.
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        case (state_r)
            ENV_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ENV_ATTACK;
                end else begin
                    state_nxt_s = ENV_IDLE;
                end
            end
            ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN: begin
                if (retrig_s) begin
                    state_nxt_s = ENV_ATTACK;
                    level_nxt_s = 8'd0;
                end else if (fall_s) begin
                    state_nxt_s = ENV_RELEASE;
                end else if (tick_s) begin
                    state_nxt_s = tick_state_s;
                    level_nxt_s = tick_level_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ENV_RELEASE: begin
                if (rise_s) begin
                    state_nxt_s = ENV_ATTACK;
                    level_nxt_s = retrig_s ? 8'd0 : level_r;
                end else if (tick_s) begin
                    state_nxt_s = tick_state_s;
                    level_nxt_s = tick_level_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ENV_IDLE;
                level_nxt_s = 8'd0;
            end
        endcase
    end

    assign prod_s = $signed(sig_in) * $signed({1'b0, level_r});

    // Envelope state, gate history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ENV_IDLE;
            level_r   <= 8'd0;
            gate_d_r  <= 1'b0;
            active_r  <= 1'b0;
            sig_out_r <= 16'd0;
        end else begin
            state_r   <= state_nxt_s;
            level_r   <= level_nxt_s;
            gate_d_r  <= gate;
            active_r  <= (state_nxt_s != ENV_IDLE);
            sig_out_r <= 16'(prod_s >>> 8);
        end
    end

    assign sig_out = sig_out_r;
    assign level   = level_r;
    assign active  = active_r;

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr with TICK_DIV = 4: ticks take effect on every
// 4th clock edge after reset release (edges 4, 8, 12, ...).
module tb_env_adsr;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [7:0]  atk_step;
    logic [7:0]  dec_step;
    logic [7:0]  sus_lvl;
    logic [7:0]  rel_step;
    logic [15:0] sig_in;
    logic [15:0] sig_out;
    logic [7:0]  level;
    logic        active;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

`ifdef ENV_RETRIG_EN
    localparam logic [15:0] RETRIG_LVL_C = 16'd0;
    localparam logic [15:0] RETRIG_TICK_C = 16'd64;
`else
    localparam logic [15:0] RETRIG_LVL_C = 16'd48;
    localparam logic [15:0] RETRIG_TICK_C = 16'd112;
`endif

    env_adsr #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .gate     (gate),
        .atk_step (atk_step),
        .dec_step (dec_step),
        .sus_lvl  (sus_lvl),
        .rel_step (rel_step),
        .sig_in   (sig_in),
        .sig_out  (sig_out),
        .level    (level),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after clock edge n (counted from reset release).
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    // Advance past edge n and stop on the following falling edge for sampling.
    task automatic at(input int n);
        go(n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0;
        atk_step = 8'd64; dec_step = 8'd32; sus_lvl = 8'd128; rel_step = 8'd16;
        sig_in = 16'h0FFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_level", {8'd0, level}, 16'd0);
        check_eq("rst_sig", sig_out, 16'd0);
        check_eq("rst_active", {15'd0, active}, 16'd0);

        // Full attack / decay / sustain sequence.
        rst = 1'b0; gate = 1'b1; cyc = 0;
        at(2);  check_eq("atk_active", {15'd0, active}, 16'd1);
        at(3);  check_eq("atk_l0", {8'd0, level}, 16'd0);
        at(4);  check_eq("atk_l64", {8'd0, level}, 16'd64);
        at(5);  check_eq("atk_sig64", sig_out, 16'h03FF);
        at(8);  check_eq("atk_l128", {8'd0, level}, 16'd128);
        at(12); check_eq("atk_l192", {8'd0, level}, 16'd192);
        at(16); check_eq("atk_l255", {8'd0, level}, 16'd255);
        at(20); check_eq("dec_l223", {8'd0, level}, 16'd223);
        at(28); check_eq("dec_l159", {8'd0, level}, 16'd159);
        at(32); check_eq("sus_l128", {8'd0, level}, 16'd128);
        at(33); check_eq("sus_sig", sig_out, 16'h07FF);

        // Release from sustain.
        gate = 1'b0;
        at(35); check_eq("rel_hold", {8'd0, level}, 16'd128);
        check_eq("rel_active", {15'd0, active}, 16'd1);
        at(36); check_eq("rel_l112", {8'd0, level}, 16'd112);
        at(60); check_eq("rel_l16", {8'd0, level}, 16'd16);
        at(64); check_eq("rel_l0", {8'd0, level}, 16'd0);
        at(65); check_eq("idle_active", {15'd0, active}, 16'd0);
        check_eq("idle_sig", sig_out, 16'd0);

        // Instant attack, sustain at full scale, negative sample scaling.
        atk_step = 8'd0; sus_lvl = 8'd255; sig_in = 16'hF000; gate = 1'b1;
        at(68); check_eq("inst_l255", {8'd0, level}, 16'd255);
        at(69); check_eq("neg_sig", sig_out, 16'hF010);
        at(72); check_eq("sus255_l", {8'd0, level}, 16'd255);
        sus_lvl = 8'd200;
        at(76); check_eq("sus_track", {8'd0, level}, 16'd200);

        // Fall coinciding with an attack tick, then re-raise.
        atk_step = 8'd64; sus_lvl = 8'd128; sig_in = 16'h0FFF; gate = 1'b0;
        do_reset();
        at(1);  gate = 1'b1;
        at(7);  check_eq("ft_l64", {8'd0, level}, 16'd64);
        gate = 1'b0;
        at(8);  check_eq("ft_hold", {8'd0, level}, 16'd64);
        at(12); check_eq("ft_rel48", {8'd0, level}, 16'd48);
        gate = 1'b1;
        at(13); check_eq("retrig_lvl", {8'd0, level}, RETRIG_LVL_C);
        at(16); check_eq("retrig_tick", {8'd0, level}, RETRIG_TICK_C);

        // Gate held through reset, then reset mid-decay.
        do_reset();
        at(2);  check_eq("gh_active", {15'd0, active}, 16'd1);
        at(4);  check_eq("gh_l64", {8'd0, level}, 16'd64);
        at(20); check_eq("gh_dec223", {8'd0, level}, 16'd223);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_level", {8'd0, level}, 16'd0);
        check_eq("mid_rst_sig", sig_out, 16'd0);
        check_eq("mid_rst_active", {15'd0, active}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 0;
        at(2);  check_eq("post_rst_active", {15'd0, active}, 16'd1);
        at(4);  check_eq("post_rst_l64", {8'd0, level}, 16'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
